// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: jump types and the memory-stage FSM states.
// Also defines the hold-register record that keeps a bus request stable while waiting.
package cpu_pkg;

  localparam logic [1:0] JT_NONE = 2'd0;
  localparam logic [1:0] JT_BEQ  = 2'd1;
  localparam logic [1:0] JT_BNE  = 2'd2;
  localparam logic [1:0] JT_J    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_hold_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus. The memory stage is the master.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the control bits and keeps the data fields;
// the load-data field only updates when a load completes.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        wreg_d,
  input  logic        m2reg_d,
  input  logic [4:0]  wn_d,
  input  logic [31:0] alu_d,
  input  logic        mo_load,
  input  logic [31:0] mo_d,
  output logic        wreg,
  output logic        m2reg,
  output logic [4:0]  wn,
  output logic [31:0] alu_result,
  output logic [31:0] mo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wreg       <= 1'b0;
      m2reg      <= 1'b0;
      wn         <= '0;
      alu_result <= '0;
      mo         <= '0;
    end else if (bubble) begin
      wreg  <= 1'b0;
      m2reg <= 1'b0;
    end else begin
      wreg       <= wreg_d;
      m2reg      <= m2reg_d;
      wn         <= wn_d;
      alu_result <= alu_d;
      if (mo_load) mo <= mo_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: variable-latency load/store with stall and timeout,
// branch/jump resolution, and the MEM/WB boundary register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMwreg,
  input  logic        MEMm2reg,
  input  logic        MEMwmem,
  input  logic        MEMisStoreHazards,
  input  logic [4:0]  MEMwn,
  input  logic [31:0] MEMaluResult,
  input  logic [31:0] MEMdi,
  input  logic [1:0]  MEMjumpType,
  input  logic [31:0] MEMjumpPc,
  input  logic        MEMzero,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic        WBwreg,
  output logic        WBm2reg,
  output logic [4:0]  WBwn,
  output logic [31:0] WBaluResult,
  output logic [31:0] WBmo,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(TIMEOUT);

  mem_state_e  state;
  cnt_t        cnt;
  dmem_hold_t  hold;

  logic        access;
  logic [31:0] wb_result;
  logic [31:0] wdata_sel;
  logic        timeout_hit;

  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        wb_bubble, wb_mo_load, wb_wreg_d;

  assign access      = MEMm2reg | MEMwmem;
  assign wb_result   = WBm2reg ? WBmo : WBaluResult;
  assign wdata_sel   = MEMisStoreHazards ? wb_result : MEMdi;
  assign timeout_hit = (state == ST_WAIT) && !dmem.ack && (cnt == CNT_MAX);

  always_comb begin
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    stall      = 1'b0;
    wb_bubble  = 1'b0;
    wb_mo_load = 1'b0;
    wb_wreg_d  = MEMwreg;
    case (state)
      ST_IDLE: if (access) begin
        bus_req   = 1'b1;
        bus_we    = MEMwmem;
        bus_addr  = MEMaluResult;
        bus_wdata = wdata_sel;
        if (dmem.ack) begin
          wb_mo_load = MEMm2reg;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      ST_WAIT: begin
        // Drive from the hold registers so the bus stays stable even if the WB
        // forwarding source changes underneath us.
        bus_req   = 1'b1;
        bus_we    = hold.we;
        bus_addr  = hold.addr;
        bus_wdata = hold.wdata;
        if (dmem.ack) begin
          wb_mo_load = MEMm2reg;
        end else if (timeout_hit) begin
          wb_wreg_d = 1'b0;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dmem.req   = bus_req;
  assign dmem.we    = bus_we;
  assign dmem.addr  = bus_addr;
  assign dmem.wdata = bus_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      hold  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (access) begin
          hold.we    <= MEMwmem;
          hold.addr  <= MEMaluResult;
          hold.wdata <= wdata_sel;
          if (!dmem.ack) begin
            state <= ST_WAIT;
            cnt   <= cnt_t'(1);
          end
        end
        ST_WAIT: begin
          if (dmem.ack || timeout_hit) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (timeout_hit) err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect = 1'b0;
    case (MEMjumpType)
      JT_BEQ:  redirect = MEMzero;
      JT_BNE:  redirect = ~MEMzero;
      JT_J:    redirect = 1'b1;
      default: redirect = 1'b0;
    endcase
  end

  assign redirectPc = MEMjumpPc;

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .bubble     (wb_bubble),
    .wreg_d     (wb_wreg_d),
    .m2reg_d    (MEMm2reg),
    .wn_d       (MEMwn),
    .alu_d      (MEMaluResult),
    .mo_load    (wb_mo_load),
    .mo_d       (dmem.rdata),
    .wreg       (WBwreg),
    .m2reg      (WBm2reg),
    .wn         (WBwn),
    .alu_result (WBaluResult),
    .mo         (WBmo)
  );

  // Load-with-write is not a legal encoding from decode.
  a_no_load_store: assert property (@(posedge clk) disable iff (rst) !(MEMm2reg && MEMwmem));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for non-memory ops and branches,
// hand-written sequences for waited, zero-wait, timeout and reset-in-wait accesses.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMwreg, MEMm2reg, MEMwmem, MEMisStoreHazards, MEMzero;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMdi, MEMjumpPc;
  logic [1:0]  MEMjumpType;
  logic        stall, redirect, WBwreg, WBm2reg, err;
  logic [31:0] redirectPc, WBaluResult, WBmo;
  logic [4:0]  WBwn;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .MEMwreg           (MEMwreg),
    .MEMm2reg          (MEMm2reg),
    .MEMwmem           (MEMwmem),
    .MEMisStoreHazards (MEMisStoreHazards),
    .MEMwn             (MEMwn),
    .MEMaluResult      (MEMaluResult),
    .MEMdi             (MEMdi),
    .MEMjumpType       (MEMjumpType),
    .MEMjumpPc         (MEMjumpPc),
    .MEMzero           (MEMzero),
    .dmem              (bus),
    .stall             (stall),
    .redirect          (redirect),
    .redirectPc        (redirectPc),
    .WBwreg            (WBwreg),
    .WBm2reg           (WBm2reg),
    .WBwn              (WBwn),
    .WBaluResult       (WBaluResult),
    .WBmo              (WBmo),
    .err               (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  jt;
    logic        zero;
    logic [31:0] jpc;
    logic        wreg;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic        ack;
    logic        exp_redir;
  } vec_t;

  vec_t v[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    MEMwreg = 0; MEMm2reg = 0; MEMwmem = 0; MEMisStoreHazards = 0; MEMzero = 0;
    MEMwn = '0; MEMaluResult = '0; MEMdi = '0; MEMjumpType = '0; MEMjumpPc = '0;
    bus.ack = 0; bus.rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int scnt;
    bit done;

    v[0] = '{2'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0};
    v[1] = '{2'd1, 1'b1, 32'h0000_0100, 1'b0, 5'd6,  32'hFFFF_FFFF, 1'b0, 1'b1};
    v[2] = '{2'd1, 1'b0, 32'h0000_0104, 1'b1, 5'd7,  32'h0000_0001, 1'b1, 1'b0};
    v[3] = '{2'd2, 1'b1, 32'h0000_0108, 1'b1, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    v[4] = '{2'd2, 1'b0, 32'h0000_010C, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
    v[5] = '{2'd3, 1'b1, 32'hDEAD_0000, 1'b1, 5'd12, 32'h0000_0077, 1'b1, 1'b1};

    // Reset state
    rst = 1;
    idle_in();
    step();
    step();
    chk("rst_wreg", WBwreg, 0);
    chk("rst_m2reg", WBm2reg, 0);
    chk("rst_wn", WBwn, 0);
    chk("rst_alu", WBaluResult, 0);
    chk("rst_mo", WBmo, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", bus.req, 0);
    rst = 0;

    // Non-memory ops and branch resolution; an ack with no access must be ignored
    for (int i = 0; i < 6; i++) begin
      idle_in();
      MEMjumpType = v[i].jt; MEMzero = v[i].zero; MEMjumpPc = v[i].jpc;
      MEMwreg = v[i].wreg; MEMwn = v[i].wn; MEMaluResult = v[i].alu;
      bus.ack = v[i].ack; bus.rdata = 32'hBAD0_0000 | 32'(i);
      @(negedge clk);
      chk($sformatf("v%0d_redirect", i), redirect, v[i].exp_redir);
      chk($sformatf("v%0d_redirectPc", i), redirectPc, v[i].jpc);
      chk($sformatf("v%0d_stall", i), stall, 0);
      chk($sformatf("v%0d_req", i), bus.req, 0);
      step();
      chk($sformatf("v%0d_wbwreg", i), WBwreg, v[i].wreg);
      chk($sformatf("v%0d_wbwn", i), WBwn, v[i].wn);
      chk($sformatf("v%0d_wbalu", i), WBaluResult, v[i].alu);
      chk($sformatf("v%0d_wbm2reg", i), WBm2reg, 0);
      chk($sformatf("v%0d_wbmo", i), WBmo, 0);
    end

    // Load at 0x40, ack 3 cycles after the request
    idle_in();
    MEMm2reg = 1; MEMwreg = 1; MEMwn = 5'd7; MEMaluResult = 32'h40;
    scnt = 0;
    for (int c = 0; c < 4; c++) begin
      bus.ack = (c == 3);
      bus.rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      if (stall) scnt++;
      chk("ld_req", bus.req, 1);
      chk("ld_addr", bus.addr, 32'h40);
      chk("ld_we", bus.we, 0);
      step();
      if (c == 0) begin
        chk("ld_bubble_wreg", WBwreg, 0);
        chk("ld_bubble_alu_hold", WBaluResult, 32'h77);
      end
      if (c == 3) idle_in();
    end
    chk("ld_stall_cycles", 32'(scnt), 3);
    chk("ld_wbmo", WBmo, 32'hDEAD_BEEF);
    chk("ld_wbm2reg", WBm2reg, 1);
    chk("ld_wbwreg", WBwreg, 1);
    chk("ld_wbwn", WBwn, 7);

    // Store forwarding the WB ALU result, ack after 2 cycles
    idle_in();
    MEMwreg = 1; MEMwn = 5'd4; MEMaluResult = 32'hA5A5_A5A5;
    step();
    MEMwreg = 0; MEMwn = 5'd0; MEMaluResult = 32'h80;
    MEMwmem = 1; MEMisStoreHazards = 1; MEMdi = 32'h0;
    scnt = 0;
    for (int c = 0; c < 3; c++) begin
      bus.ack = (c == 2);
      bus.rdata = (c == 2) ? 32'h1111_1111 : 32'h0;
      @(negedge clk);
      if (stall) scnt++;
      chk("st_wdata", bus.wdata, 32'hA5A5_A5A5);
      chk("st_we", bus.we, 1);
      chk("st_addr", bus.addr, 32'h80);
      step();
      if (c == 2) idle_in();
    end
    chk("st_stall_cycles", 32'(scnt), 2);
    chk("st_wbmo_kept", WBmo, 32'hDEAD_BEEF);
    chk("st_wbwreg", WBwreg, 0);
    chk("st_wbalu", WBaluResult, 32'h80);

    // Zero-wait load followed back-to-back by a zero-wait store
    idle_in();
    MEMm2reg = 1; MEMwreg = 1; MEMwn = 5'd3; MEMaluResult = 32'h44;
    bus.ack = 1; bus.rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("zw_ld_stall", stall, 0);
    chk("zw_ld_req", bus.req, 1);
    step();
    idle_in();
    MEMwmem = 1; MEMaluResult = 32'h48; MEMdi = 32'h1234_5678;
    bus.ack = 1; bus.rdata = 32'h2222_2222;
    @(negedge clk);
    chk("zw_ld_wbmo", WBmo, 32'hCAFE_F00D);
    chk("zw_ld_wbwn", WBwn, 3);
    chk("zw_st_stall", stall, 0);
    chk("zw_st_req", bus.req, 1);
    chk("zw_st_wdata", bus.wdata, 32'h1234_5678);
    step();
    idle_in();
    chk("zw_st_wbwreg", WBwreg, 0);
    chk("zw_st_wbalu", WBaluResult, 32'h48);

    // Timeout: no ack ever arrives
    chk("to_err_before", err, 0);
    MEMm2reg = 1; MEMwreg = 1; MEMwn = 5'd9; MEMaluResult = 32'h90;
    scnt = 0;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (stall) scnt++;
      else done = 1;
      step();
    end
    idle_in();
    chk("to_stall_cycles", 32'(scnt), TMO);
    chk("to_err", err, 1);
    chk("to_wbwreg", WBwreg, 0);
    chk("to_wbwn", WBwn, 9);
    MEMwreg = 1; MEMwn = 5'd2; MEMaluResult = 32'h55;
    @(negedge clk);
    chk("after_to_stall", stall, 0);
    chk("after_to_req", bus.req, 0);
    step();
    chk("after_to_wbwreg", WBwreg, 1);
    chk("after_to_wbwn", WBwn, 2);
    chk("after_to_wbalu", WBaluResult, 32'h55);
    chk("after_to_err_sticky", err, 1);

    // Reset while waiting for an ack
    idle_in();
    MEMm2reg = 1; MEMwreg = 1; MEMwn = 5'd10; MEMaluResult = 32'hA0;
    step();
    @(negedge clk);
    chk("rw_stall_in_wait", stall, 1);
    rst = 1;
    idle_in();
    step();
    chk("rw_req", bus.req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_wbwreg", WBwreg, 0);
    chk("rw_wbm2reg", WBm2reg, 0);
    chk("rw_wbwn", WBwn, 0);
    chk("rw_wbalu", WBaluResult, 0);
    chk("rw_wbmo", WBmo, 0);
    chk("rw_err", err, 0);
    rst = 0;
    step();
    chk("rw_req_after", bus.req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
